avalon_mm_cmd_master: RTL and testbench

//  Avalon-MM master (initiator) that turns single read/write commands from FPGA fabric into
//  bus transactions against Qsys slaves (PIOs, register files) in Computer_System.

---
 rtl/avalon_mm_cmd_master.sv | 174 +++++++++++++++++
 tb/tb_avalon_mm_cmd_master.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_mm_cmd_master.sv
// Avalon-MM master: turns single read/write commands from fabric logic into
// bus transactions, one at a time, with a bus timeout on stalled slaves.
module avalon_mm_cmd_master #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_be,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_error,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid
);

  localparam int BE_W = DATA_W / 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WR     = 3'd1;
  localparam logic [2:0] S_RD     = 3'd2;
  localparam logic [2:0] S_RDWAIT = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  // Count value seen during the TIMEOUT-th busy cycle (counter starts at 0).
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_error_q, rsp_error_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              timeout_hit;

  assign timeout_hit = (cnt_q == CNT_LAST);

  // Next-state logic: command capture, bus handshakes, timeout and response pulse.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    read_d      = read_q;
    write_d     = write_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          be_d    = cmd_be;
          cnt_d   = '0;
          err_d   = 1'b0;
          if (cmd_write) begin
            write_d = 1'b1;
            state_d = S_WR;
          end else begin
            read_d  = 1'b1;
            state_d = S_RD;
          end
        end
      end
      S_WR: begin
        // Completion in the last allowed cycle takes priority over the timeout.
        if (!avm_waitrequest) begin
          write_d = 1'b0;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          write_d = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RD: begin
        if (!avm_waitrequest && avm_readdatavalid) begin
          read_d  = 1'b0;
          rdata_d = avm_readdata;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          read_d  = 1'b0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (!avm_waitrequest) begin
            read_d  = 1'b0;
            state_d = S_RDWAIT;
          end
        end
      end
      S_RDWAIT: begin
        if (avm_readdatavalid) begin
          rdata_d = avm_readdata;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        rsp_error_d = err_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any transaction without a response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      read_q      <= read_d;
      write_q     <= write_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rdata_q     <= rdata_d;
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign avm_byteenable = be_q;
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_error      = rsp_error_q;
  assign rsp_rdata      = rdata_q;

endmodule

// File: tb/tb_avalon_mm_cmd_master.sv
// Bench for avalon_mm_cmd_master: a reactive slave model with per-command
// stall settings, a transaction-level reference model and a scoreboard.
module tb_avalon_mm_cmd_master;

  localparam int ADDR_W  = 16;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 255;
  localparam int NEVER   = -1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [15:0]       cmd_addr = '0;
  logic [31:0]       cmd_wdata = '0;
  logic [3:0]        cmd_be = '0;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;
  logic [15:0]       avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [3:0]        avm_byteenable;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest = 1'b0;
  logic [31:0]       avm_readdata = '0;
  logic              avm_readdatavalid = 1'b0;

  avalon_mm_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_be(cmd_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] merge_be(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

  // ---------------- slave model (environment) ----------------
  logic [31:0] smem [16];
  int          s_wait = 0;
  int          s_d = 0;
  int          s_cnt = 0;
  int          s_pend = 0;
  int          s_pend_idx = 0;
  bit          s_prev_strobe = 0;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      avm_readdatavalid = 1'b0;
      avm_readdata      = $urandom;
      if (!reset_n) begin
        s_pend = 0;
        s_cnt = 0;
        s_prev_strobe = 0;
        avm_waitrequest = 1'($urandom_range(1));
      end else begin
        if (s_pend > 0) begin
          s_pend--;
          if (s_pend == 0) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = smem[s_pend_idx];
          end
        end
        if (avm_read || avm_write) begin
          s_cnt = s_prev_strobe ? s_cnt + 1 : 0;
          avm_waitrequest = (s_cnt < s_wait);
          if (!avm_waitrequest) begin
            if (avm_write) begin
              smem[avm_address[5:2]] = merge_be(smem[avm_address[5:2]], avm_writedata, avm_byteenable);
            end else if (s_d == 0) begin
              avm_readdatavalid = 1'b1;
              avm_readdata      = smem[avm_address[5:2]];
            end else if (s_d != NEVER) begin
              s_pend     = s_d;
              s_pend_idx = int'(avm_address[5:2]);
            end
          end
          s_prev_strobe = 1;
        end else begin
          avm_waitrequest = 1'($urandom_range(1));
          s_prev_strobe = 0;
        end
        // Stray readdatavalid where the master must ignore it.
        if (!avm_readdatavalid && s_pend == 0 && (cmd_ready || avm_write) &&
            $urandom_range(3) == 0) begin
          avm_readdatavalid = 1'b1;
        end
      end
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int          acc_cyc;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    bit          wr;
    logic [15:0] addr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem_m [16];
  logic [31:0] last_rd = '0;
  int          issued = 0;
  int          responses = 0;

  task automatic issue(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                       input logic [3:0] be, input int w, input int d, input bit hold_after);
    exp_t e;
    int   busy;
    int   guard;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_be    = be;
    guard = 0;
    while (!cmd_ready) begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        $display("FAIL cmd_ready_timeout: got 0, expected 1");
        $fatal(1, "cmd_ready never returned");
      end
    end
    // Accepted at the coming rising edge.
    s_wait = w;
    s_d    = d;
    if (wr) busy = w + 1;
    else if (d == NEVER) busy = TIMEOUT + 1;
    else busy = w + 1 + d;
    e.err = (busy > TIMEOUT);
    e.lat = e.err ? TIMEOUT + 2 : busy + 2;
    if (!e.err) begin
      if (wr) mem_m[addr[5:2]] = merge_be(mem_m[addr[5:2]], data, be);
      else    last_rd = mem_m[addr[5:2]];
    end
    e.rdata   = last_rd;
    e.acc_cyc = cyc;
    e.wr      = wr;
    e.addr    = addr;
    exp_q.push_back(e);
    issued++;
    @(negedge clk);
    if (!hold_after) cmd_valid = 1'b0;
  endtask

  // Monitor: pops expectations on each response and checks protocol rules.
  logic [15:0] p_addr;
  logic [31:0] p_wdata;
  logic [3:0]  p_be;
  logic        p_rd = 0, p_wr = 0;
  int          overlap_cnt = 0;
  int          unstable_cnt = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      p_rd <= 1'b0;
      p_wr <= 1'b0;
    end else begin
      if (avm_read && avm_write) overlap_cnt++;
      // avm_waitrequest here is still the value sampled at the last rising edge.
      if ((p_rd || p_wr) && avm_waitrequest && (avm_read || avm_write)) begin
        if (avm_address !== p_addr || avm_writedata !== p_wdata || avm_byteenable !== p_be ||
            avm_read !== p_rd || avm_write !== p_wr) unstable_cnt++;
      end
      p_addr  <= avm_address;
      p_wdata <= avm_writedata;
      p_be    <= avm_byteenable;
      p_rd    <= avm_read;
      p_wr    <= avm_write;
      if (rsp_valid) begin
        responses++;
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("rsp %s addr=0x%0h lat=%0d err=%0b rdata=0x%08h",
                   e.wr ? "WR" : "RD", e.addr, cyc - e.acc_cyc, rsp_error, rsp_rdata);
          check("latency", 32'(cyc - e.acc_cyc), 32'(e.lat));
          check("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
          check("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
    end
  end

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 16; i++) begin
      smem[i]  = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
      mem_m[i] = smem[i];
    end

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_avm_read", {31'd0, avm_read}, 32'd0);
    check("rst_avm_write", {31'd0, avm_write}, 32'd0);
    check("rst_avm_address", {16'd0, avm_address}, 32'd0);
    check("rst_avm_writedata", avm_writedata, 32'd0);
    check("rst_avm_byteenable", {28'd0, avm_byteenable}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_error", {31'd0, rsp_error}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed: PIO write, stalled read, unmapped-read timeout.
    issue(1'b1, 16'h0010, 32'h5, 4'hF, 0, 0, 1'b0);
    drain();
    issue(1'b0, 16'h0010, 32'h0, 4'hF, 4, 2, 1'b0);
    drain();
    issue(1'b0, 16'h0010, 32'h0, 4'hF, 0, NEVER, 1'b0);
    drain();

    // Four commands with cmd_valid held high throughout.
    issue(1'b1, 16'h0004, 32'h1111_2222, 4'hF, 1, 0, 1'b1);
    issue(1'b0, 16'h0004, 32'h0, 4'hF, 0, 1, 1'b1);
    issue(1'b1, 16'h0008, 32'hDEAD_BEEF, 4'h6, 2, 0, 1'b1);
    issue(1'b0, 16'h0008, 32'h0, 4'hF, 0, 0, 1'b0);
    drain();

    // Boundaries: completion in the last allowed cycle, and one cycle too late.
    issue(1'b1, 16'h0020, 32'h0BAD_F00D, 4'hF, TIMEOUT - 1, 0, 1'b0);
    issue(1'b0, 16'h0020, 32'h0, 4'hF, 0, TIMEOUT - 1, 1'b0);
    issue(1'b1, 16'h0024, 32'h1234_5678, 4'hF, TIMEOUT, 0, 1'b0);
    issue(1'b0, 16'h0024, 32'h0, 4'hF, TIMEOUT - 5, 4, 1'b0);
    drain();

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      bit          wr;
      int          w;
      int          d;
      logic [15:0] a;
      wr = 1'($urandom_range(1));
      a  = 16'({$urandom_range(15), 2'b00});
      w  = $urandom_range(5);
      d  = ($urandom_range(9) == 9) ? NEVER : $urandom_range(3);
      issue(wr, a, $urandom, 4'($urandom_range(15)), w, d, n != 39 && $urandom_range(1) == 1);
    end
    drain();

    // Reset in the middle of a stalled write: no response, master back to idle.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'h0030;
    cmd_wdata = 32'hFFFF_FFFF;
    cmd_be    = 4'hF;
    s_wait    = 100000;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_wr_avm_write", {31'd0, avm_write}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_abort_avm_write", {31'd0, avm_write}, 32'd0);
    check("rst_abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    last_rd = '0;
    repeat (6) @(negedge clk);
    check("rst_abort_rdata", rsp_rdata, 32'd0);
    issue(1'b0, 16'h0030, 32'h0, 4'hF, 1, 1, 1'b0);
    drain();

    check("no_strobe_overlap", 32'(overlap_cnt), 32'd0);
    check("avm_stable_in_wait", 32'(unstable_cnt), 32'd0);
    check("response_count", 32'(responses), 32'(issued));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
